mode_counter: RTL and testbench
===============================

MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits (2..32).
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1: upper terminal value (1..2**WIDTH-1).
REQ-003 Parameter PRESCALE, default 1: the counter steps once per PRESCALE enabled cycles (1..65535).
REQ-004 Port clk  input  1: the single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1: one clock; reset is asynchronous and active-low.
REQ-006 Port enable  input  1: when high, prescaler and counting advance.
REQ-007 Port dir  input  1: count direction, 1 = up, 0 = down.
REQ-008 Port mode  input  2: 00 = wrap, 01 = saturate, 10 = one-shot, 11 = reserved (behaves as wrap).
REQ-009 Port clear  input  1: synchronous clear.
REQ-010 Port load  input  1: synchronous load strobe.
REQ-011 Port load_val  input  WIDTH: value taken on load.
REQ-012 Port start  input  1: one-shot arm strobe.
REQ-013 Port data_out  output  WIDTH: current count, registered.
REQ-014 Port tc  output  1: registered one-cycle terminal-count pulse.
REQ-015 Port done  output  1: one-shot complete flag, registered.

Function
REQ-016 Priority per edge: clear > load > counting step; start is evaluated only when clear and load are low.
REQ-017 Clear: data_out=0, prescaler=0, FSM to IDLE, tc=0, done=0.
REQ-018 Load: data_out=min(load_val, MAX_VAL), prescaler=0, FSM state unchanged, tc=0.
REQ-019 Step strobe: prescaler counts enabled cycles 0..PRESCALE-1; step occurs on the enabled cycle where it equals PRESCALE-1, then it returns to 0; PRESCALE=1 gives a step on every enabled cycle.
REQ-020 enable low: data_out, prescaler and FSM hold; tc=0.
REQ-021 Terminal: up terminal = MAX_VAL, down terminal = 0.
REQ-022 Wrap mode: step up from MAX_VAL gives 0, step down from 0 gives MAX_VAL; tc=1 in the cycle after each wrap step.
REQ-023 Saturate mode: step into a terminal gives tc=1 in the following cycle; further steps at the terminal hold data_out with tc=0.
REQ-024 One-shot FSM states IDLE, RUN and DONE; the count steps only in RUN.
REQ-025 IDLE->RUN on start; RUN->DONE on the step that lands on the terminal (tc=1, done=1 in the next cycle); DONE->RUN on start, with data_out reloaded to 0 (dir=1) or MAX_VAL (dir=0); start in RUN is ignored.
REQ-026 Changing dir or mode mid-count takes effect on the next step; no glitch and no spurious tc.
REQ-027 Leaving one-shot mode forces the FSM to IDLE and done=0 on the next edge.

Reset
REQ-028 reset low asynchronously forces data_out=0, prescaler=0, FSM=IDLE, tc=0 and done=0.
REQ-029 Release is synchronous to clk; the first step can occur on the first edge after deassertion.

Structure
REQ-030 Shared package mode_counter_pkg holds the mode encodings (MODE_WRAP, MODE_SAT, MODE_ONESHOT) and the FSM state type.
REQ-031 Sub-module step_prescaler (parameter PRESCALE; ports clk, reset, enable, clr, step) generates the step strobe.

Verification
REQ-032 WIDTH=4, MAX_VAL=9, PRESCALE=1, wrap, dir=1, enable from 0 -> sequence 0..9,0; tc high exactly one cycle, with data_out=0.
REQ-033 Same setup, dir=0, load_val=2 loaded -> sequence 2,1,0,9; tc pulse once; load_val=15 -> data_out=9.
REQ-034 Saturate, dir=1, 12 steps -> data_out stops at 9; tc pulses once only.
REQ-035 One-shot, dir=1, start -> counts 0..9, done=1 and holds 9; a second start -> 0 and counts again; clear and load asserted together -> data_out=0.
REQ-036 PRESCALE=3, wrap, enable toggled -> one step per 3 enabled cycles; counting holds while enable=0.
REQ-037 reset pulled low mid-count (data_out=5, one-shot RUN) between edges -> outputs 0 immediately; after release, FSM in IDLE.

Source files
------------

// File: rtl/mode_counter_pkg.sv
// Shared encodings for the mode counter: mode field values, one-shot FSM states
// and the prescaler counter width.
package mode_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int unsigned PRESCALE_W = 16;

endpackage

// File: rtl/step_prescaler.sv
// Divides enabled cycles by PRESCALE; step is high on the enabled cycle that
// completes each group of PRESCALE.
module step_prescaler
  import mode_counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clr,
  output logic step
);

  localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks use blocking '=' with a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PRESCALE_W'(1);
    end
  end

  // NOTE: state registers use non-blocking '<=' and take the asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign step = enable && (cnt_q == LAST);

endmodule

// File: rtl/mode_counter.sv
// Up/down counter with wrap, saturate and one-shot modes, prescaled stepping,
// synchronous clear/load and registered tc/done flags.
module mode_counter
  import mode_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 32'((64'd1 << WIDTH) - 64'd1),
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  mode_e            cur_mode;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             step;
  logic [WIDTH-1:0] term, nxt_wrap, nxt_sat;
  logic             at_term;

  assign cur_mode = mode_e'(mode);

  step_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clr    (clear | load),
    .step   (step)
  );

  assign term     = dir ? MAX_C : '0;
  assign at_term  = (data_q == term);
  assign nxt_sat  = at_term ? data_q : (dir ? data_q + WIDTH'(1) : data_q - WIDTH'(1));
  assign nxt_wrap = at_term ? (dir ? '0 : MAX_C) : nxt_sat;

  always_comb begin
    data_d  = data_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    state_d = state_q;
    if (clear) begin
      data_d  = '0;
      done_d  = 1'b0;
      state_d = ST_IDLE;
    end else if (load) begin
      data_d = (load_val > MAX_C) ? MAX_C : load_val;
    end else if (enable) begin
      case (cur_mode)
        MODE_SAT: begin
          if (step && !at_term) begin
            data_d = nxt_sat;
            tc_d   = (nxt_sat == term);
          end
        end
        MODE_ONESHOT: begin
          case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
              if (step) begin
                data_d = nxt_sat;
                if (nxt_sat == term) begin
                  state_d = ST_DONE;
                  tc_d    = 1'b1;
                  done_d  = 1'b1;
                end
              end
            end
            ST_DONE: begin
              if (start) begin
                state_d = ST_RUN;
                done_d  = 1'b0;
                data_d  = dir ? '0 : MAX_C;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
        default: begin
          // Wrap and the reserved encoding share behaviour.
          if (step) begin
            data_d = nxt_wrap;
            tc_d   = at_term;
          end
        end
      endcase
    end
    if (cur_mode != MODE_ONESHOT) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      data_q  <= data_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      state_q <= state_d;
    end
  end

  assign data_out = data_q;
  assign tc       = tc_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mode_counter.sv
// Scoreboard bench for mode_counter: two instances (PRESCALE 1 and 3, WIDTH 4,
// MAX_VAL 9); expectations are queued as stimulus is driven and checked after each edge.
module tb_mode_counter;
  import mode_counter_pkg::*;

  typedef struct {
    string      tag;
    logic [3:0] d;
    logic       tc;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0, dir = 1'b1, clear = 1'b0, load = 1'b0, start = 1'b0;
  logic [1:0] mode = MODE_WRAP;
  logic [3:0] load_val = '0;
  logic [3:0] data_out;
  logic       tc, done;

  logic       en3 = 1'b0;
  logic [3:0] data_out3;
  logic       tc3, done3;

  int   total = 0;
  int   bad   = 0;
  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  mode_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .mode(mode),
    .clear(clear), .load(load), .load_val(load_val), .start(start),
    .data_out(data_out), .tc(tc), .done(done)
  );

  mode_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) u_dut3 (
    .clk(clk), .reset(reset), .enable(en3), .dir(1'b1), .mode(2'b00),
    .clear(1'b0), .load(1'b0), .load_val(4'd0), .start(1'b0),
    .data_out(data_out3), .tc(tc3), .done(done3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input string tag, input int d, input bit t, input bit dn);
    exp_t e;
    e.tag = tag; e.d = 4'(d); e.tc = t; e.done = dn;
    q1.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick3(input string tag, input int d, input bit t);
    exp_t e;
    e.tag = tag; e.d = 4'(d); e.tc = t; e.done = 1'b0;
    q3.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check({e.tag, "_data"}, 32'(data_out), 32'(e.d));
        check({e.tag, "_tc"},   32'(tc),       32'(e.tc));
        check({e.tag, "_done"}, 32'(done),     32'(e.done));
      end
      if (q3.size() != 0) begin
        e = q3.pop_front();
        check({e.tag, "_data"}, 32'(data_out3), 32'(e.d));
        check({e.tag, "_tc"},   32'(tc3),       32'(e.tc));
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int cnt;
    int steps;
    bit is_step;

    #1 reset = 1'b0;
    #2;
    check("rst_data", 32'(data_out), 0);
    check("rst_tc",   32'(tc),       0);
    check("rst_done", 32'(done),     0);
    check("rst_data3", 32'(data_out3), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Wrap up-count from enable low: 0..9 then 0 with a single tc.
    tick("a_off", 0, 0, 0);
    enable = 1'b1;
    for (int i = 1; i <= 11; i++) tick("a_up", i % 10, i == 10, 0);
    dir = 1'b0; tick("a_dir_dn", 0, 0, 0);
    dir = 1'b1; tick("a_dir_up", 1, 0, 0);
    enable = 1'b0;
    tick("a_hold", 1, 0, 0);
    tick("a_hold", 1, 0, 0);
    enable = 1'b1; clear = 1'b1;
    tick("a_clr", 0, 0, 0);
    clear = 1'b0;

    // Wrap down-count from a loaded value, then clamp an oversized load.
    dir = 1'b0; load = 1'b1; load_val = 4'd2;
    tick("b_load", 2, 0, 0);
    load = 1'b0;
    tick("b_dn", 1, 0, 0);
    tick("b_dn", 0, 0, 0);
    tick("b_wrap", 9, 1, 0);
    tick("b_dn", 8, 0, 0);
    load = 1'b1; load_val = 4'd15;
    tick("b_clamp", 9, 0, 0);
    load = 1'b0;

    // Saturate up: stops at 9, tc once.
    clear = 1'b1;
    tick("c_clr", 0, 0, 0);
    clear = 1'b0; mode = MODE_SAT; dir = 1'b1;
    for (int i = 1; i <= 12; i++) tick("c_sat", (i < 9) ? i : 9, i == 9, 0);

    // One-shot: arm, run to 9, re-arm, start ignored while running.
    clear = 1'b1;
    tick("d_clr", 0, 0, 0);
    clear = 1'b0; mode = MODE_ONESHOT; start = 1'b1;
    tick("d_arm", 0, 0, 0);
    start = 1'b0;
    for (int i = 1; i <= 9; i++) tick("d_run", i, i == 9, i == 9);
    tick("d_done", 9, 0, 1);
    tick("d_done", 9, 0, 1);
    start = 1'b1;
    tick("d_rearm", 0, 0, 0);
    start = 1'b0;
    for (int i = 1; i <= 3; i++) tick("d_run2", i, 0, 0);
    start = 1'b1;
    tick("d_ign_start", 4, 0, 0);
    start = 1'b0; clear = 1'b1; load = 1'b1; load_val = 4'd7;
    tick("d_clr_ld", 0, 0, 0);
    clear = 1'b0; load = 1'b0;
    tick("d_idle", 0, 0, 0);

    // Leaving one-shot from DONE drops done and resumes wrap counting.
    start = 1'b1;
    tick("e_arm", 0, 0, 0);
    start = 1'b0; load = 1'b1; load_val = 4'd8;
    tick("e_load_run", 8, 0, 0);
    load = 1'b0;
    tick("e_done", 9, 1, 1);
    mode = MODE_WRAP;
    tick("e_exit", 0, 1, 0);
    tick("e_wrap", 1, 0, 0);

    // Asynchronous reset mid-run.
    clear = 1'b1;
    tick("f_clr", 0, 0, 0);
    clear = 1'b0; mode = MODE_ONESHOT; start = 1'b1;
    tick("f_arm", 0, 0, 0);
    start = 1'b0;
    for (int i = 1; i <= 5; i++) tick("f_run", i, 0, 0);
    #2 reset = 1'b0;
    #1;
    check("f_async_data", 32'(data_out), 0);
    check("f_async_tc",   32'(tc),       0);
    check("f_async_done", 32'(done),     0);
    @(negedge clk);
    reset = 1'b1;
    tick("f_idle", 0, 0, 0);
    start = 1'b1;
    tick("f_arm2", 0, 0, 0);
    start = 1'b0;
    tick("f_run2", 1, 0, 0);

    // Prescaled instance: one step per three enabled cycles.
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      en3 = (i < 4) ? 1'b1 : ((i < 6) ? 1'b0 : 1'($urandom_range(0, 1)));
      if (en3) cnt++;
      steps   = cnt / 3;
      is_step = en3 && (cnt % 3 == 0);
      tick3("g_presc", steps % 10, is_step && (steps % 10 == 0));
    end
    en3 = 1'b0;

    @(posedge clk);
    #2;
    check("q_drain", 32'(q1.size() + q3.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
